pc_gen_v2: RTL

- Parametrised fetch-address generator for the 5-stage MIPS pipeline; replaces the single-register PC with EPC bypass.
- Owns the F-stage PC register and arbitrates redirect sources: exception entry, eret return, and D-stage branch/jump.
- Buffers one redirect that arrives while fetch is stalled.
- Produces a registered instruction-fetch address-error flag (AdEL) aligned with the PC it describes.

---
 rtl/pc_gen_v2.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pc_gen_v2.sv
// ---------------------------------------------------------------------------
// pc_gen_v2 -- fetch-address generator for the 5-stage MIPS pipeline.
//
// Owns the F-stage PC register. It arbitrates the redirect sources in this
// priority order: exception entry, eret return, D-stage branch/jump. When
// fetch is stalled it buffers one redirect. Alongside the PC it registers an
// instruction-fetch address-error flag (AdEL) that describes that same PC.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   en         in   1 = F stage may advance, 0 = stall
//   exc_req    in   exception/interrupt taken; flush to HANDLER_PC
//   eret       in   eret resolved in D; return to epc
//   epc        in   return address from CP0
//   br_valid   in   D-stage branch/jump taken
//   br_target  in   branch/jump target
//   pc         out  current fetch address
//   pc_valid   out  1 = real fetch, 0 = bubble (treat IM result as nop)
//   exc_adel   out  pc misaligned or outside [IM_BEGIN, IM_END]; only
//                   meaningful when pc_valid = 1
//   pend_busy  out  a redirect is buffered and waiting for en
// ---------------------------------------------------------------------------
module pc_gen_v2 #(
    parameter int unsigned           WIDTH      = 32,
    parameter logic [WIDTH-1:0]      RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      HANDLER_PC = 32'h0000_4180,
    parameter logic [WIDTH-1:0]      IM_BEGIN   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      IM_END     = 32'h0000_6ffc,
    parameter int unsigned           STEP       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             exc_adel,
    output logic             pend_busy
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             adel_q, adel_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    // Records whether the buffered redirect came from an eret. In that case
    // applying it from PEND must also produce the squash bubble.
    logic             pend_eret_q, pend_eret_d;
    logic [WIDTH-1:0] redir_pc;

    // -----------------------------------------------------------------------
    // State / PC register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            adel_q      <= 1'b0;
            pend_pc_q   <= '0;
            pend_eret_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            adel_q      <= adel_d;
            pend_pc_q   <= pend_pc_d;
            pend_eret_q <= pend_eret_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-PC arbitration
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = 1'b1;
        pend_pc_d   = pend_pc_q;
        pend_eret_d = pend_eret_q;
        redir_pc    = eret ? epc : br_target;   // eret beats branch

        if (exc_req) begin
            // Exception entry ignores the stall and drops any buffered redirect.
            pc_d        = HANDLER_PC;
            state_d     = RUN;
            pend_eret_d = 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    // The single bubble after reset: pc stays at RESET_PC.
                    state_d = RUN;
                end
                RUN, PEND: begin
                    if (eret || br_valid) begin
                        if (en) begin
                            pc_d    = redir_pc;
                            state_d = RUN;
                            valid_d = !eret;
                        end else begin
                            // Latest redirect overwrites any earlier buffered one.
                            pend_pc_d   = redir_pc;
                            pend_eret_d = eret;
                            state_d     = PEND;
                        end
                    end else if (en) begin
                        if (state_q == PEND) begin
                            pc_d    = pend_pc_q;
                            state_d = RUN;
                            valid_d = !pend_eret_q;
                        end else begin
                            pc_d = pc_q + STEP_W;   // wraps modulo 2^WIDTH
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // AdEL describes the PC being registered. A bubble never reports it.
        adel_d = valid_d && ((pc_d[1:0] != 2'b00) ||
                             (pc_d < IM_BEGIN) ||
                             (pc_d > IM_END));
    end

    assign pc        = pc_q;
    assign pc_valid  = valid_q;
    assign exc_adel  = adel_q;
    assign pend_busy = (state_q == PEND);

endmodule
